// File: rtl/frame_write_ctrl.sv
// Frame write controller: streams accepted pixels into a banked frame buffer,
// pads every line out to STRIDE words and publishes the completed bank.
module frame_write_ctrl #(
  parameter int              IMG_W     = 103,
  parameter int              IMG_H     = 103,
  parameter int              STRIDE    = 110,
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 15,
  parameter int              BANKS     = 2,
  parameter int              PAD_EN    = 1,
  parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow_err
);

  localparam int XW = $clog2(STRIDE + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam bit PAD_ON = (PAD_EN == 1) && (STRIDE > IMG_W);
  localparam logic [XW-1:0]     X_LAST_PIX  = XW'(IMG_W - 1);
  localparam logic [XW-1:0]     X_FIRST_PAD = XW'(IMG_W);
  localparam logic [XW-1:0]     X_LAST_PAD  = XW'(STRIDE - 1);
  localparam logic [YW-1:0]     Y_LAST      = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] BANK_SPAN   = ADDR_W'(STRIDE * IMG_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [ADDR_W-1:0] line_base_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              overflow_err_r;
  logic              in_ready_s;
  logic              busy_s;
  logic              frame_done_s;
  logic              accept_s;
  logic              drop_s;
  logic              pix_last_s;
  logic              pad_last_s;
  logic              line_end_s;
  logic              frame_end_s;

  // A line ends on its last pixel (no padding) or on its last pad word.
  assign accept_s    = (state_r == RUN) && in_valid;
  assign drop_s      = in_valid && !in_ready_s;
  assign pix_last_s  = accept_s && (x_r == X_LAST_PIX);
  assign pad_last_s  = (state_r == PAD) && (x_r == X_LAST_PAD);
  assign line_end_s  = (pix_last_s && !PAD_ON) || pad_last_s;
  assign frame_end_s = line_end_s && (y_r == Y_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (pix_last_s && PAD_ON) begin
          state_nxt_s = PAD;
        end else if (frame_end_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      PAD: begin
        if (frame_end_s) begin
          state_nxt_s = DONE;
        end else if (pad_last_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PAD;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    in_ready_s   = 1'b0;
    busy_s       = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b0;
      end
      RUN: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      PAD: begin
        busy_s = 1'b1;
      end
      DONE: begin
        frame_done_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Position counters, running line base address, write port and banks.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      line_base_r <= {ADDR_W{1'b0}};
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            line_base_r <= ((BANKS == 2) && wr_bank_r) ? BANK_SPAN : {ADDR_W{1'b0}};
          end
        end
        RUN: begin
          if (accept_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= line_base_r + ADDR_W'(x_r);
            wr_data_r <= in_data;
            if (pix_last_s && PAD_ON) begin
              x_r <= X_FIRST_PAD;
            end else if (line_end_s) begin
              x_r <= {XW{1'b0}};
              if (!frame_end_s) begin
                y_r         <= y_r + YW'(1);
                line_base_r <= line_base_r + STRIDE_A;
              end
            end else begin
              x_r <= x_r + XW'(1);
            end
          end
        end
        PAD: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= line_base_r + ADDR_W'(x_r);
          wr_data_r <= PAD_VALUE;
          if (pad_last_s) begin
            x_r <= {XW{1'b0}};
            if (!frame_end_s) begin
              y_r         <= y_r + YW'(1);
              line_base_r <= line_base_r + STRIDE_A;
            end
          end else begin
            x_r <= x_r + XW'(1);
          end
        end
        DONE: begin
          rd_bank_r <= wr_bank_r;
          if (BANKS == 2) begin
            wr_bank_r <= ~wr_bank_r;
          end
        end
        default: begin
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a pixel dropped on the start cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err_r <= 1'b0;
    end else if (drop_s) begin
      overflow_err_r <= 1'b1;
    end else if ((state_r == IDLE) && start) begin
      overflow_err_r <= 1'b0;
    end
  end

  assign in_ready     = in_ready_s;
  assign busy         = busy_s;
  assign frame_done   = frame_done_s;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign rd_bank      = rd_bank_r;
  assign overflow_err = overflow_err_r;

endmodule
